// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - time-multiplexed FFT stage sequencer around one external butterfly datapath
module fft_stage_sequencer #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8,
  localparam int N_STAGES  = $clog2(N_SAMPLES),
  localparam int SW        = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  recv_msg_real,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  recv_msg_imag,
  input  logic                                 recv_val,
  output logic                                 recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  send_msg_imag,
  output logic                                 send_val,
  input  logic                                 send_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  stage_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  stage_msg_imag,
  output logic                                 stage_val,
  input  logic                                 stage_rdy,
  output logic [SW-1:0]                        stage_idx,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  stage_ret_real,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  stage_ret_imag,
  input  logic                                 stage_ret_val,
  output logic                                 stage_ret_rdy,
  output logic                                 busy
);

  // Fixed-point format is only carried through; reject configurations that cannot be an FFT frame.
  if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0)) begin : g_bad_len
    $error("fft_stage_sequencer: N_SAMPLES must be a power of two >= 2");
  end
  if ((DECIMAL_PT < 0) || (DECIMAL_PT >= BIT_WIDTH)) begin : g_bad_frac
    $error("fft_stage_sequencer: DECIMAL_PT must lie inside the sample word");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);

  state_e                               state_q, state_d;
  logic [SW-1:0]                        stage_cnt_q, stage_cnt_d;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  buf_real_q, buf_real_d;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  buf_imag_q, buf_imag_d;
  // Low through reset and for the first edge after release, so recv_rdy stays low while reset
  // is asserted even though the state register already reads IDLE.
  logic                                 live_q;

  // State, stage counter and frame buffer registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      stage_cnt_q <= '0;
      buf_real_q  <= '0;
      buf_imag_q  <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      buf_real_q  <= buf_real_d;
      buf_imag_q  <= buf_imag_d;
      live_q      <= 1'b1;
    end
  end

  // Next-state and handshake decode; outputs depend on registered state only.
  always_comb begin
    state_d       = state_q;
    stage_cnt_d   = stage_cnt_q;
    buf_real_d    = buf_real_q;
    buf_imag_d    = buf_imag_q;
    recv_rdy      = 1'b0;
    stage_val     = 1'b0;
    stage_ret_rdy = 1'b0;
    send_val      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        recv_rdy = live_q;
        if (live_q && recv_val) begin
          buf_real_d  = recv_msg_real;
          buf_imag_d  = recv_msg_imag;
          stage_cnt_d = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stage_val = 1'b1;
        if (stage_rdy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stage_ret_rdy = 1'b1;
        if (stage_ret_val) begin
          buf_real_d = stage_ret_real;
          buf_imag_d = stage_ret_imag;
          if (stage_cnt_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            stage_cnt_d = stage_cnt_q + SW'(1);
            state_d     = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        send_val = 1'b1;
        if (send_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The buffer feeds both the datapath and the consumer; the val flags say which one it is meant for.
  assign stage_msg_real = buf_real_q;
  assign stage_msg_imag = buf_imag_q;
  assign send_msg_real  = buf_real_q;
  assign send_msg_imag  = buf_imag_q;
  assign stage_idx      = stage_cnt_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;

  localparam int BW = 32;
  localparam int N  = 8;
  localparam int SW = 2;
  localparam int FW = N * BW;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0][BW-1:0]   recv_msg_real, recv_msg_imag;
  logic                   recv_val, recv_rdy;
  logic [N-1:0][BW-1:0]   send_msg_real, send_msg_imag;
  logic                   send_val, send_rdy;
  logic [N-1:0][BW-1:0]   stage_msg_real, stage_msg_imag;
  logic                   stage_val, stage_rdy;
  logic [SW-1:0]          stage_idx;
  logic [N-1:0][BW-1:0]   stage_ret_real, stage_ret_imag;
  logic                   stage_ret_val, stage_ret_rdy;
  logic                   busy;
  logic                   garbage;

  int checks   = 0;
  int failures = 0;
  int cyc;
  logic [11:0] idx_log;

  fft_stage_sequencer #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(N)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .recv_msg_real  (recv_msg_real),
    .recv_msg_imag  (recv_msg_imag),
    .recv_val       (recv_val),
    .recv_rdy       (recv_rdy),
    .send_msg_real  (send_msg_real),
    .send_msg_imag  (send_msg_imag),
    .send_val       (send_val),
    .send_rdy       (send_rdy),
    .stage_msg_real (stage_msg_real),
    .stage_msg_imag (stage_msg_imag),
    .stage_val      (stage_val),
    .stage_rdy      (stage_rdy),
    .stage_idx      (stage_idx),
    .stage_ret_real (stage_ret_real),
    .stage_ret_imag (stage_ret_imag),
    .stage_ret_val  (stage_ret_val),
    .stage_ret_rdy  (stage_ret_rdy),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stub: real += 1, imag unchanged; garbage forces junk for the spurious-return test.
  always_comb begin
    stage_ret_real = '0;
    stage_ret_imag = '0;
    for (int k = 0; k < N; k++) begin
      stage_ret_real[k] = garbage ? 32'hDEADBEEF : stage_msg_real[k] + 32'd1;
      stage_ret_imag[k] = garbage ? 32'h0BAD0BAD : stage_msg_imag[k];
    end
  end

  function automatic logic [FW-1:0] mk(input int base, input int step);
    logic [N-1:0][BW-1:0] f;
    for (int k = 0; k < N; k++) f[k] = BW'(base + k * step);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a frame, wait (bounded) for acceptance; returns at the first cycle after accept.
  task automatic accept(input logic [FW-1:0] r, input logic [FW-1:0] i);
    int n;
    n = 0;
    recv_msg_real = r;
    recv_msg_imag = i;
    recv_val      = 1'b1;
    while (!recv_rdy && n < 20) begin
      tick();
      n++;
    end
    chk("accept_rdy", recv_rdy, 1);
    tick();
    recv_val = 1'b0;
  endtask

  // Called in cycle 1 after accept; runs until send_val, logging issued stage indices.
  task automatic wait_done();
    cyc     = 1;
    idx_log = '0;
    while (cyc < 40) begin
      if (stage_val && stage_rdy) idx_log = (idx_log << 4) | 12'(stage_idx);
      if (send_val) break;
      tick();
      cyc++;
    end
    chk("done_reached", send_val, 1);
  endtask

  task automatic finish_frame(input string tag, input logic [FW-1:0] er, input logic [FW-1:0] ei);
    chk({tag, "_real"}, send_msg_real, er);
    chk({tag, "_imag"}, send_msg_imag, ei);
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rdy"}, recv_rdy, 1);
    chk({tag, "_idle_sval"}, send_val, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    recv_val      = 1'b0;
    recv_msg_real = '0;
    recv_msg_imag = '0;
    send_rdy      = 1'b0;
    stage_rdy     = 1'b1;
    stage_ret_val = 1'b1;
    garbage       = 1'b0;

    // Reset state
    #2;
    chk("rst_recv_rdy", recv_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stage_val", stage_val, 0);
    chk("rst_ret_rdy", stage_ret_rdy, 0);
    chk("rst_send_val", send_val, 0);
    chk("rst_idx", stage_idx, 0);
    chk("rst_buf", send_msg_real, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_rdy_low", recv_rdy, 0);
    tick();
    chk("rel_rdy_high", recv_rdy, 1);

    // Test 1: nominal frame, latency and stage index order
    accept(mk(0, 1), mk(0, 0));
    chk("t1_issue_val", stage_val, 1);
    chk("t1_busy", busy, 1);
    chk("t1_recv_rdy", recv_rdy, 0);
    wait_done();
    chk("t1_latency", cyc, 7);
    chk("t1_idx_seq", idx_log, 12'h012);
    finish_frame("t1", mk(3, 1), mk(0, 0));

    // Test 2: consumer back-pressure in DONE
    accept(mk(10, 1), mk(0, 1));
    wait_done();
    for (int j = 0; j < 5; j++) begin
      chk("t2_hold_val", send_val, 1);
      chk("t2_hold_data", send_msg_real, mk(13, 1));
      chk("t2_hold_rdy", recv_rdy, 0);
      tick();
    end
    chk("t2_sixth_val", send_val, 1);
    finish_frame("t2", mk(13, 1), mk(0, 1));

    // Test 3: datapath not ready for 3 cycles at stage 1
    accept(mk(32, 1), mk(5, 0));
    tick();
    stage_rdy = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      chk("t3_stall_val", stage_val, 1);
      chk("t3_stall_idx", stage_idx, 1);
      chk("t3_stall_msg", stage_msg_real, mk(33, 1));
      if (j < 2) tick();
    end
    stage_rdy = 1'b1;
    tick();
    chk("t3_wait_rdy", stage_ret_rdy, 1);
    chk("t3_wait_sval", stage_val, 0);
    chk("t3_wait_idx", stage_idx, 1);
    wait_done();
    finish_frame("t3", mk(35, 1), mk(5, 0));

    // Test 4: reset pulse during WAIT of stage 2
    accept(mk(64, 1), mk(0, 0));
    for (int j = 0; j < 5; j++) tick();
    chk("t4_pre_ret_rdy", stage_ret_rdy, 1);
    chk("t4_pre_idx", stage_idx, 2);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ret_rdy", stage_ret_rdy, 0);
    chk("t4_rst_stage_val", stage_val, 0);
    chk("t4_rst_send_val", send_val, 0);
    chk("t4_rst_recv_rdy", recv_rdy, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_idx", stage_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_rel_rdy", recv_rdy, 1);
    accept(mk(0, 1), mk(0, 0));
    wait_done();
    chk("t4_latency", cyc, 7);
    finish_frame("t4", mk(3, 1), mk(0, 0));

    // Test 5: back-to-back frames with recv_val held high
    recv_msg_real = mk(100, 1);
    recv_msg_imag = mk(7, 0);
    recv_val      = 1'b1;
    tick();
    recv_msg_real = mk(200, 1);
    recv_msg_imag = mk(0, 2);
    wait_done();
    chk("t5_done_rdy", recv_rdy, 0);
    chk("t5_a_real", send_msg_real, mk(103, 1));
    chk("t5_a_imag", send_msg_imag, mk(7, 0));
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    chk("t5_gap_busy", busy, 0);
    chk("t5_gap_rdy", recv_rdy, 1);
    tick();
    recv_val = 1'b0;
    chk("t5_b_busy", busy, 1);
    chk("t5_b_msg", stage_msg_real, mk(200, 1));
    wait_done();
    finish_frame("t5_b", mk(203, 1), mk(0, 2));

    // Test 6: spurious stage_ret_val with garbage while in ISSUE
    accept(mk(0, 1), mk(0, 0));
    stage_rdy = 1'b0;
    garbage   = 1'b1;
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("t6_issue_val", stage_val, 1);
      chk("t6_buf_real", stage_msg_real, mk(0, 1));
      chk("t6_buf_imag", stage_msg_imag, mk(0, 0));
    end
    garbage   = 1'b0;
    stage_rdy = 1'b1;
    wait_done();
    finish_frame("t6", mk(3, 1), mk(0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
